// File: rtl/bal_spd_shaper.sv
// Motor speed output stage: per-channel slew limiting, soft start, ramp-down
// on power loss and a consecutive-sample debounce of the too-fast indication.
module bal_spd_shaper #(
  parameter int SPD_W     = 12,
  parameter int SLEW_STEP = 8,
  parameter int TF_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [SPD_W-1:0] lft_tgt,
  input  logic [SPD_W-1:0] rght_tgt,
  input  logic             too_fast_in,
  input  logic             pwr_up,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             spd_vld,
  output logic             too_fast,
  output logic             ramp_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RAMP_DN = 2'd2
  } state_t;

  localparam logic signed [SPD_W:0] STEP_POS = (SPD_W+1)'(SLEW_STEP);
  localparam logic signed [SPD_W:0] STEP_NEG = -STEP_POS;
  localparam logic [SPD_W-1:0]      STEP_U   = SPD_W'(SLEW_STEP);
  localparam logic [3:0]            TF_LAST  = 4'(TF_CNT - 1);

  state_t           state_q, state_d, mode;
  logic [SPD_W-1:0] lft_q, lft_d, rght_q, rght_d;
  logic [SPD_W-1:0] lft_goal, rght_goal;
  logic             vld_q, vld_d;
  logic             tf_q, tf_d;
  logic             busy_q, busy_d;
  logic [3:0]       cnt_q, cnt_d;

  // One extra bit keeps the difference exact for full-scale reversals.
  function automatic logic [SPD_W-1:0] slew(input logic [SPD_W-1:0] spd,
                                            input logic [SPD_W-1:0] tgt);
    logic signed [SPD_W:0] diff;
    diff = $signed({tgt[SPD_W-1], tgt}) - $signed({spd[SPD_W-1], spd});
    if (diff > STEP_POS)      return spd + STEP_U;
    else if (diff < STEP_NEG) return spd - STEP_U;
    else                      return tgt;
  endfunction

  always_comb begin
    // The rule applied this cycle follows the state pwr_up selects now.
    mode = state_q;
    case (state_q)
      IDLE:    if (pwr_up)  mode = RUN;
      RUN:     if (!pwr_up) mode = RAMP_DN;
      RAMP_DN: if (pwr_up)  mode = RUN;
      default: mode = IDLE;
    endcase

    lft_goal  = (mode == RUN) ? lft_tgt  : '0;
    rght_goal = (mode == RUN) ? rght_tgt : '0;

    state_d = mode;
    lft_d   = lft_q;
    rght_d  = rght_q;
    vld_d   = 1'b0;
    tf_d    = tf_q;
    cnt_d   = cnt_q;

    if (mode == IDLE) begin
      tf_d  = 1'b0;
      cnt_d = '0;
    end else if (vld_in) begin
      lft_d  = slew(lft_q, lft_goal);
      rght_d = slew(rght_q, rght_goal);
      vld_d  = 1'b1;
      if (too_fast_in != tf_q) begin
        if (cnt_q == TF_LAST) begin
          tf_d  = ~tf_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = '0;
      end
      if (mode == RAMP_DN && lft_d == '0 && rght_d == '0) state_d = IDLE;
    end

    busy_d = (state_d == RAMP_DN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lft_q   <= '0;
      rght_q  <= '0;
      vld_q   <= 1'b0;
      tf_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      vld_q   <= vld_d;
      tf_q    <= tf_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lft_spd   = lft_q;
  assign rght_spd  = rght_q;
  assign spd_vld   = vld_q;
  assign too_fast  = tf_q;
  assign ramp_busy = busy_q;

endmodule

// File: tb/tb_bal_spd_shaper.sv
// Directed and randomized bench for bal_spd_shaper with an integer reference
// model of slew limiting, power sequencing and too-fast debounce.
module tb_bal_spd_shaper;

  localparam int SPD_W = 12;
  localparam int STEP  = 8;
  localparam int TFC   = 4;

  // clock / reset block
  logic             clk = 1'b0;
  logic             rst;
  logic             vld_in, too_fast_in, pwr_up;
  logic [SPD_W-1:0] lft_tgt, rght_tgt;
  logic [SPD_W-1:0] lft_spd, rght_spd;
  logic             spd_vld, too_fast, ramp_busy;

  always #5 clk = ~clk;

  bal_spd_shaper #(.SPD_W(SPD_W), .SLEW_STEP(STEP), .TF_CNT(TFC)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .lft_tgt(lft_tgt),
    .rght_tgt(rght_tgt), .too_fast_in(too_fast_in), .pwr_up(pwr_up),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld),
    .too_fast(too_fast), .ramp_busy(ramp_busy)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: 0 = off, 1 = running, 2 = ramping down
  int m_st = 0, m_l = 0, m_r = 0, m_vld = 0, m_tf = 0, m_cnt = 0;

  function automatic int toward(int cur, int tgt);
    int d;
    d = tgt - cur;
    if (d > STEP) d = STEP;
    if (d < -STEP) d = -STEP;
    return cur + d;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit v, input bit p, input int lt, input int rt,
                       input bit tfi, input bit r);
    int nxt;
    if (r) begin
      m_st = 0; m_l = 0; m_r = 0; m_vld = 0; m_tf = 0; m_cnt = 0;
      return;
    end
    nxt = p ? 1 : (m_st == 0 ? 0 : 2);
    m_vld = 0;
    if (nxt == 0) begin
      m_tf = 0; m_cnt = 0;
    end else if (v) begin
      m_l = toward(m_l, nxt == 1 ? lt : 0);
      m_r = toward(m_r, nxt == 1 ? rt : 0);
      m_vld = 1;
      if (int'(tfi) != m_tf) m_cnt++; else m_cnt = 0;
      if (m_cnt == TFC) begin m_tf = 1 - m_tf; m_cnt = 0; end
      if (nxt == 2 && m_l == 0 && m_r == 0) nxt = 0;
    end
    m_st = nxt;
  endtask

  // driver: apply one cycle of inputs, advance the model, check all outputs
  task automatic cyc(input bit v, input bit p, input int lt, input int rt,
                     input bit tfi, input bit r);
    logic [31:0] lv, rv;
    lv = lt; rv = rt;
    vld_in = v; pwr_up = p; too_fast_in = tfi; rst = r;
    lft_tgt = lv[SPD_W-1:0]; rght_tgt = rv[SPD_W-1:0];
    @(posedge clk);
    model(v, p, lt, rt, tfi, r);
    #1;
    chk("lft_spd",   $signed(lft_spd),  m_l);
    chk("rght_spd",  $signed(rght_spd), m_r);
    chk("spd_vld",   int'(spd_vld),     m_vld);
    chk("too_fast",  int'(too_fast),    m_tf);
    chk("ramp_busy", int'(ramp_busy),   int'(m_st == 2));
  endtask

  initial begin
    int soft_exp[5];
    int tf_seq[12];
    int tf_exp[12];
    soft_exp = '{8, 16, 24, 30, 30};
    tf_seq   = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    tf_exp   = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};

    // reset held with activity on the inputs
    for (int i = 0; i < 3; i++) cyc(1, 1, 100, -100, 1, 1);
    chk("reset_lft", $signed(lft_spd), 0);
    // idle: vld_in ignored
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 50, 50, 1, 0);
      chk("idle_no_vld", int'(spd_vld), 0);
    end

    // soft start
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 30, 0, 0, 0);
      chk("soft_start", $signed(lft_spd), soft_exp[i]);
    end
    cyc(0, 1, 30, 0, 0, 0);
    chk("hold_no_vld", int'(spd_vld), 0);

    // settle at 20 / -13, then power-down ramp
    for (int i = 0; i < 4; i++) cyc(1, 1, 20, -13, 0, 0);
    cyc(1, 0, 20, -13, 0, 0);
    chk("ramp1_lft", $signed(lft_spd), 12);
    chk("ramp1_rght", $signed(rght_spd), -5);
    chk("ramp1_busy", int'(ramp_busy), 1);
    cyc(0, 0, 20, -13, 0, 0);
    cyc(1, 0, 99, 99, 0, 0);
    chk("ramp2_lft", $signed(lft_spd), 4);
    chk("ramp2_rght", $signed(rght_spd), 0);
    cyc(1, 0, 99, 99, 0, 0);
    chk("ramp3_lft", $signed(lft_spd), 0);
    chk("ramp3_vld", int'(spd_vld), 1);
    chk("ramp3_idle", int'(ramp_busy), 0);
    cyc(1, 0, 99, 99, 0, 0);
    chk("after_ramp_idle", int'(spd_vld), 0);

    // restart, partial ramp, resume from 12
    for (int i = 0; i < 3; i++) cyc(1, 1, 20, -13, 0, 0);
    cyc(1, 0, 20, -13, 0, 0);
    chk("resume_pre", $signed(lft_spd), 12);
    cyc(1, 1, 20, -13, 0, 0);
    chk("resume_lft", $signed(lft_spd), 20);
    chk("resume_rght", $signed(rght_spd), -13);
    chk("resume_busy", int'(ramp_busy), 0);

    // full-scale reversal
    for (int i = 0; i < 260; i++) cyc(1, 1, 2047, 0, 0, 0);
    chk("fs_top", $signed(lft_spd), 2047);
    for (int i = 0; i < 512; i++) begin
      cyc(1, 1, -2048, 0, 0, 0);
      if (i == 510) chk("fs_511", $signed(lft_spd), -2041);
    end
    chk("fs_bottom", $signed(lft_spd), -2048);

    // too_fast debounce
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, -2048, 0, tf_seq[i][0], 0);
      chk("tf_debounce", int'(too_fast), tf_exp[i]);
    end

    // mid-ramp reset with too_fast set
    for (int i = 0; i < 4; i++) cyc(1, 1, -2048, 0, 1, 0);
    chk("tf_set", int'(too_fast), 1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("mid_ramp_busy", int'(ramp_busy), 1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("mid_rst_lft", $signed(lft_spd), 0);
    chk("mid_rst_tf", int'(too_fast), 0);
    chk("mid_rst_busy", int'(ramp_busy), 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("mid_rst_idle", int'(spd_vld), 0);

    // randomized traffic
    begin
      bit p;
      p = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 19) == 0) p = ~p;
        cyc(bit'($urandom_range(0, 2) != 0), p,
            int'($urandom_range(0, 4095)) - 2048,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) - 30
                                        : int'($urandom_range(0, 4095)) - 2048,
            bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 199) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bal_spd_shaper.md
# bal_spd_shaper

Parametrised motor-speed output stage placed between the Segway math stage and the motor drive interface. It registers the per-update left/right speed targets and limits how fast each channel can change, by at most SLEW_STEP counts per valid update. It provides a soft start on power-up and a controlled ramp-down to zero on power-down. It also debounces the too_fast indication over a configurable number of consecutive updates before reporting it.

## Interface
- SPD_W, 12: width of the signed speed targets and outputs (two's complement); legal range 8..16.
- SLEW_STEP, 8: maximum magnitude of change per update, in speed counts; legal range 1..2^(SPD_W-2).
- TF_CNT, 4: number of consecutive updates required to set or clear too_fast; legal range 1..15.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- vld_in  input  1  one-cycle strobe; lft_tgt, rght_tgt and too_fast_in are valid in this cycle.
- lft_tgt  input  SPD_W  signed left motor speed target.
- rght_tgt  input  SPD_W  signed right motor speed target.
- too_fast_in  input  1  raw too-fast indication from the math stage.
- pwr_up  input  1  level; balance control is enabled.
- lft_spd  output  SPD_W  signed, slew-limited left speed.
- rght_spd  output  SPD_W  signed, slew-limited right speed.
- spd_vld  output  1  one-cycle strobe; lft_spd and rght_spd were updated this cycle.
- too_fast  output  1  debounced too-fast flag.
- ramp_busy  output  1  high while in state RAMP_DN.

## Operation
- **States and transitions:**
  - IDLE: outputs are held at 0. Go to RUN when pwr_up=1.
  - RUN: outputs track the targets. Go to RAMP_DN when pwr_up=0.
  - RAMP_DN: outputs are stepped toward 0. Go to IDLE when pwr_up=0 and both outputs equal 0 after a step. Go back to RUN when pwr_up=1.
- **Update rule (per channel), applied in RUN on each vld_in:**
  - Compute diff = tgt - spd at SPD_W+1 bits, sign-extended.
  - If |diff| <= SLEW_STEP, then spd = tgt.
  - Otherwise spd = spd + SLEW_STEP when diff>0, or spd - SLEW_STEP when diff<0.
  - The result never overshoots the target and never wraps. Full-scale steps, e.g. -2048 to +2047, are handled by the extra bit.
- **RAMP_DN:** on each vld_in, apply the same rule with tgt forced to 0. lft_tgt and rght_tgt are ignored.
- **IDLE:**
  - vld_in produces no spd_vld and no output change.
  - The too_fast debounce counter is cleared and too_fast=0.
- **Power transitions are hitless:**
  - RUN entered from IDLE starts slewing from 0.
  - RUN re-entered from RAMP_DN continues from the present output value, with no jump.
- **Simultaneous events:**
  - The state transition is decided from pwr_up in the same cycle as vld_in. That vld_in is then processed under the new state's rule.
  - Example: pwr_up falls together with vld_in. That update steps toward 0.
- **too_fast debounce (RUN and RAMP_DN only):**
  - A saturating counter tracks consecutive vld_in samples whose too_fast_in value differs from the current too_fast.
  - The counter resets to 0 whenever a sample matches too_fast.
  - On reaching TF_CNT, too_fast toggles and the counter resets to 0.
  - Cycles without vld_in do not affect the counter.
- **Reset (rst=1), in any state:**
  - state=IDLE, lft_spd=0, rght_spd=0, spd_vld=0, too_fast=0, ramp_busy=0, debounce counter=0.
  - Reset asserted in the middle of a ramp forces zero outputs on the next edge.

## Timing
- Latency is one cycle from vld_in to updated outputs. vld_in sampled at edge N produces new lft_spd/rght_spd and spd_vld=1 after edge N, valid throughout cycle N+1.
- spd_vld is high for exactly one cycle per processed vld_in. Back-to-back vld_in gives back-to-back spd_vld.
- Outputs are registered and hold their value between updates.
- A state change takes effect on the edge after pwr_up changes. ramp_busy is registered and follows the state.
- The too_fast change is registered on the same edge as the qualifying update, so it appears with that update's spd_vld.
- The transition RAMP_DN→IDLE occurs on the edge where the final step makes both outputs 0. spd_vld still pulses for that final step.

## Test plan
- **Reset and idle:** with rst=1, vld_in pulses and pwr_up=1 -> all outputs 0. Release rst with pwr_up=0 and apply vld_in -> spd_vld stays 0.
- **Soft start:** with SLEW_STEP=8, pwr_up=1 and lft_tgt=30 on 5 consecutive vld_in -> lft_spd sequence 8, 16, 24, 30, 30, each output one cycle after its vld_in.
- **Full-scale reversal:** with SPD_W=12, outputs settled at +2047, then target -2048 -> each update decreases the output by 8 with no wrap, reaching exactly -2048 after 512 updates.
- **Power-down ramp:** with lft_spd=20, rght_spd=-13 and pwr_up dropping together with vld_in -> ramp_busy=1, lft 12/4/0 and rght -5/0/0, then IDLE after the 3rd update. Re-asserting pwr_up at lft=12 -> RUN resumes from 12.
- **too_fast debounce:** with TF_CNT=4, too_fast_in=1 on 3 updates, then 0, then 4 updates of 1 -> too_fast=0 until the 4th consecutive 1, then 1. Four consecutive 0 samples clear it.
- **Mid-ramp reset:** assert rst for one cycle during RAMP_DN -> the next cycle shows outputs 0, state IDLE and too_fast=0.
